// File: rtl/weight_sram_pipe.sv
// weight_sram_pipe: parametrised single-port weight SRAM model with lane-masked writes,
// a fixed-latency read pipeline with valid strobe, and a zero-fill clear engine.
module weight_sram_pipe #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 18,
  parameter int LANE_W = 9,
  parameter int READ_LAT = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       CK,
  input  logic                       RSTB,
  input  logic                       CS,
  input  logic                       WEB,
  input  logic [DATA_W/LANE_W-1:0]   BWEB,
  input  logic [ADDR_W-1:0]          A,
  input  logic [DATA_W-1:0]          DI,
  input  logic                       OE,
  input  logic                       CLR,
  output logic [DATA_W-1:0]          DO,
  output logic                       VALID,
  output logic                       READY,
  output logic                       BUSY
);
  localparam int LANES = DATA_W / LANE_W;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  localparam logic [0:0] RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              acc;
  logic              rd;
  logic              pv [READ_LAT];
  logic [DATA_W-1:0] pd [READ_LAT];

  assign READY = state == IDLE;
  assign BUSY  = state == CLEAR;
  assign acc   = RSTB && CS && READY;
  assign rd    = acc && WEB;
  assign VALID = pv[READ_LAT-1];
  assign DO    = OE ? pd[READ_LAT-1] : '0;

  always_ff @(posedge CK)
    if (!RSTB) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      state <= CLR ? CLEAR : IDLE;
    end else begin
      cnt   <= cnt + 1'b1;
      state <= &cnt ? IDLE : CLEAR;
    end

  // Clear writes and host writes never collide: the host is locked out while clearing.
  always_ff @(posedge CK)
    if (RSTB && state == CLEAR)
      mem[cnt] <= '0;
    else if (acc && !WEB)
      for (int i = 0; i < LANES; i++)
        if (!BWEB[i]) mem[A][i*LANE_W +: LANE_W] <= DI[i*LANE_W +: LANE_W];

  // The last stage doubles as the DO register, so it only loads on a valid result.
  for (genvar g = 0; g < READ_LAT; g++) begin : g_pipe
    logic              in_v;
    logic [DATA_W-1:0] in_d;
    if (g == 0) begin : g_head
      assign in_v = rd;
      assign in_d = mem[A];
    end else begin : g_body
      assign in_v = pv[g-1];
      assign in_d = pd[g-1];
    end
    always_ff @(posedge CK) begin
      pv[g] <= RSTB && in_v;
      if (!RSTB) pd[g] <= '0;
      else if (g < READ_LAT - 1 || in_v) pd[g] <= in_d;
    end
  end
endmodule

// File: tb/tb_weight_sram_pipe.sv
// tb_weight_sram_pipe: scoreboard bench for weight_sram_pipe, one default instance and one
// small READ_LAT=3 instance with clear-on-reset.
module tb_weight_sram_pipe;
  logic CK = 1'b0;
  always #5 CK = ~CK;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct {
    logic [17:0] d;
    int          c;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  logic        a_rstb, a_cs, a_web, a_oe, a_clr, a_valid, a_ready, a_busy;
  logic [1:0]  a_bweb;
  logic [13:0] a_a;
  logic [17:0] a_di, a_do;
  logic        b_rstb, b_cs, b_web, b_oe, b_clr, b_valid, b_ready, b_busy;
  logic [1:0]  b_bweb;
  logic [3:0]  b_a;
  logic [17:0] b_di, b_do;
  int          busy_n;
  int          ready_bad;

  weight_sram_pipe #(.CLEAR_ON_RESET(0)) u0 (
    .CK(CK), .RSTB(a_rstb), .CS(a_cs), .WEB(a_web), .BWEB(a_bweb), .A(a_a), .DI(a_di),
    .OE(a_oe), .CLR(a_clr), .DO(a_do), .VALID(a_valid), .READY(a_ready), .BUSY(a_busy)
  );

  weight_sram_pipe #(.ADDR_W(4), .READ_LAT(3), .CLEAR_ON_RESET(1)) u1 (
    .CK(CK), .RSTB(b_rstb), .CS(b_cs), .WEB(b_web), .BWEB(b_bweb), .A(b_a), .DI(b_di),
    .OE(b_oe), .CLR(b_clr), .DO(b_do), .VALID(b_valid), .READY(b_ready), .BUSY(b_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge CK)
    if (a_valid === 1'b1) begin
      chk("u0_valid_expected", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("u0_do", 32'(a_do), 32'(e0.d));
        chk("u0_latency", cyc, e0.c);
      end
    end

  always @(negedge CK)
    if (b_valid === 1'b1) begin
      chk("u1_valid_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("u1_do", 32'(b_do), 32'(e1.d));
        chk("u1_latency", cyc, e1.c);
      end
    end

  task automatic wr0(input logic [13:0] a, input logic [17:0] d, input logic [1:0] bw);
    a_cs = 1; a_web = 0; a_a = a; a_di = d; a_bweb = bw;
    @(posedge CK); #1;
    a_cs = 0;
  endtask

  task automatic rd0(input logic [13:0] a, input logic [17:0] exp);
    a_cs = 1; a_web = 1; a_a = a; a_di = 18'($urandom); a_bweb = 2'($urandom);
    q0.push_back('{exp, cyc + 1});
    @(posedge CK); #1;
    a_cs = 0;
  endtask

  task automatic wr1(input logic [3:0] a, input logic [17:0] d);
    b_cs = 1; b_web = 0; b_a = a; b_di = d; b_bweb = 2'b00;
    @(posedge CK); #1;
    b_cs = 0;
  endtask

  task automatic rd1(input logic [3:0] a, input logic [17:0] exp);
    b_cs = 1; b_web = 1; b_a = a; b_di = 18'($urandom); b_bweb = 2'($urandom);
    q1.push_back('{exp, cyc + 3});
    @(posedge CK); #1;
    b_cs = 0;
  endtask

  task automatic clear_window(input int clr_at);
    busy_n = 0;
    ready_bad = 0;
    for (int i = 0; i < 40; i++) begin
      b_cs = (i == 2 || i == 5);
      b_web = (i != 5);
      b_a = (i == 5) ? 4'd3 : 4'd7;
      b_di = '1;
      b_bweb = 2'b00;
      b_clr = (i == clr_at);
      @(negedge CK);
      if (!b_busy) break;
      busy_n++;
      if (b_ready) ready_bad++;
      @(posedge CK); #1;
    end
    b_cs = 0;
    b_clr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    a_rstb = 0; a_cs = 0; a_web = 1; a_bweb = 0; a_a = 0; a_di = 0; a_oe = 1; a_clr = 0;
    b_rstb = 0; b_cs = 0; b_web = 1; b_bweb = 0; b_a = 0; b_di = 0; b_oe = 1; b_clr = 0;
    repeat (3) @(posedge CK);
    #1;
    chk("u0_rst_valid", a_valid, 0);
    chk("u0_rst_do", a_do, 0);
    chk("u1_rst_valid", b_valid, 0);
    chk("u1_rst_do", b_do, 0);
    chk("u1_rst_busy", b_busy, 1);
    a_rstb = 1;
    @(posedge CK); #1;
    chk("u0_idle_ready", a_ready, 1);
    chk("u0_idle_busy", a_busy, 0);
    // full write, lane masks, no-op write, read-after-write
    wr0(14'h5, 18'h2A5A5, 2'b00); rd0(14'h5, 18'h2A5A5);
    wr0(14'h5, 18'h3FFFF, 2'b10); rd0(14'h5, 18'h2A5FF);
    wr0(14'h5, 18'h00000, 2'b01); rd0(14'h5, 18'h001FF);
    wr0(14'h5, 18'h3FFFF, 2'b11); rd0(14'h5, 18'h001FF);
    wr0(14'h6, 18'h12345, 2'b00); wr0(14'h3FFF, 18'h0ABCD, 2'b00);
    rd0(14'h6, 18'h12345); rd0(14'h3FFF, 18'h0ABCD); rd0(14'h5, 18'h001FF);
    wr0(14'h9, 18'h3AAAA, 2'b00);
    chk("u0_do_hold_after_write", a_do, 18'h001FF);
    chk("u0_write_no_valid", a_valid, 0);
    // OE gates DO only
    a_oe = 0;
    wr0(14'h7, 18'h2A5A5, 2'b00);
    rd0(14'h7, 18'h00000);
    @(posedge CK); #1;
    a_oe = 1;
    #1;
    chk("u0_oe_do", a_do, 18'h2A5A5);
    chk("u0_oe_no_valid", a_valid, 0);
    // clear-on-reset window, requests dropped
    b_rstb = 1;
    clear_window(-1);
    chk("u1_clr_len", busy_n, 16);
    chk("u1_clr_ready_low", ready_bad, 0);
    chk("u1_ready_after_clr", b_ready, 1);
    @(posedge CK); #1;
    for (int i = 0; i < 16; i++) rd1(4'(i), 18'h0);
    repeat (4) @(posedge CK);
    #1;
    // READ_LAT=3 back-to-back
    wr1(4'd1, 18'h11); wr1(4'd2, 18'h22); wr1(4'd3, 18'h33);
    rd1(4'd1, 18'h11); rd1(4'd2, 18'h22); rd1(4'd3, 18'h33);
    repeat (5) @(posedge CK);
    #1;
    chk("u1_do_hold", b_do, 18'h33);
    // read accepted with CLR returns pre-clear data; mid-clear reset restarts
    wr1(4'd9, 18'h155); wr1(4'd15, 18'h3FFFF);
    b_cs = 1; b_web = 1; b_a = 4'd9; b_clr = 1;
    q1.push_back('{18'h155, cyc + 3});
    @(posedge CK); #1;
    b_cs = 0; b_clr = 0;
    repeat (7) @(posedge CK);
    #1;
    chk("u1_busy_mid", b_busy, 1);
    b_rstb = 0;
    @(posedge CK); #1;
    b_rstb = 1;
    clear_window(4);
    chk("u1_restart_len", busy_n, 16);
    chk("u1_restart_ready_low", ready_bad, 0);
    @(posedge CK); #1;
    rd1(4'd9, 18'h0); rd1(4'd15, 18'h0); rd1(4'd1, 18'h0);
    repeat (6) @(posedge CK);
    #1;
    chk("u0_queue_drained", q0.size(), 0);
    chk("u1_queue_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/weight_sram_pipe.md
Name: weight_sram_pipe

Overview:
Parametrised single-port weight SRAM behavioural model, the next generation of the team's fixed 16384x18 weight macro model. Adds configurable depth and width, per-lane write masking, a configurable read-latency pipeline with a data-valid strobe, and a hardware clear engine that zero-fills the array after reset or on request. It sits between the weight loader/DMA and the PE-array weight fetch path.

Parameters:
ADDR_W, 14, address width; depth DEPTH = 2**ADDR_W words
DATA_W, 18, word width in bits
LANE_W, 9, write-mask lane width; DATA_W must be a multiple of LANE_W; LANES = DATA_W/LANE_W
READ_LAT, 1, read latency in cycles, legal range 1..4
CLEAR_ON_RESET, 1, 1 = start a zero-fill automatically when reset is released

Ports:
CK  in  1  clock, all logic on rising edge
RSTB  in  1  synchronous active-low reset
CS  in  1  request strobe
WEB  in  1  0 = write, 1 = read
BWEB  in  LANES  per-lane write enable, active low; lane i covers DI[i*LANE_W +: LANE_W]
A  in  ADDR_W  word address
DI  in  DATA_W  write data
OE  in  1  output enable; 0 forces DO to all zeros (no tri-states)
CLR  in  1  single-cycle pulse requesting a zero-fill
DO  out  DATA_W  read data
VALID  out  1  one-cycle strobe: DO holds a new read result
READY  out  1  1 = a request with CS=1 is accepted this cycle
BUSY  out  1  1 = clear engine active

Behaviour:
- Reset is sampled only on CK rising edge with RSTB=0. While RSTB=0: VALID=0, read pipeline flushed, internal DO register=0, clear counter=0. The state after reset is CLEAR if CLEAR_ON_RESET=1, otherwise IDLE. Memory contents are not reset by RSTB.
- FSM has two states.
  - IDLE: READY=1, BUSY=0.
  - CLEAR: READY=0, BUSY=1.
- IDLE -> CLEAR when CLR=1. A CS=1 request in the same cycle as CLR is accepted first, then the clear begins.
- CLEAR: on each cycle, writes all-zero to Memory[cnt], then cnt increments. After the write to DEPTH-1, the FSM returns to IDLE and cnt wraps to 0. A clear takes exactly DEPTH cycles, and READY is high again on cycle DEPTH+1 after the CLEAR entry edge.
- CLR while in CLEAR is ignored, with no restart. RSTB=0 mid-clear aborts the clear; if CLEAR_ON_RESET=1, the clear restarts from address 0.
- A request is accepted when CS=1 and READY=1. CS while READY=0 is dropped, with no queueing.
- Write (WEB=0): for each lane i with BWEB[i]=0, Memory[A] lane i <= DI lane i. Other lanes are unchanged. A write produces no VALID pulse and does not change DO.
- BWEB all ones with WEB=0 is a legal no-op write.
- Read (WEB=1): Memory[A] is sampled at the accept edge and travels through a READ_LAT-deep shift register together with a valid bit. At the READ_LAT-th edge after acceptance, VALID=1 for one cycle and the DO register loads the data.
- Back-to-back reads are accepted every cycle, and responses emerge in order every cycle.
- Read-after-write: a read accepted on the cycle after a write to the same A returns the new, lane-merged data.
- DO register holds the last read data until the next VALID. DO = OE ? DO register : 0, purely combinational. OE does not affect VALID.
- Reads already in flight when a clear starts still complete with their pre-clear data.
- BWEB is ignored for reads. DI is ignored for reads.

Test Plan:
1. Defaults, CLEAR_ON_RESET=0: write A=0x0005 DI=0x2A5A5 BWEB=00, then read A=5 -> one cycle later VALID=1, DO=0x2A5A5.
2. Lane mask: after case 1, write A=5 DI=0x3FFFF BWEB=10 (lane1 masked), then read -> DO=0x2A5FF, since the low 9 bits are updated and the upper lane is kept.
3. READ_LAT=3: reads issued on consecutive cycles to A=1,2,3, holding 0x11, 0x22, 0x33 -> VALID high on cycles 3, 4, 5 after the first accept, with DO=0x11, 0x22, 0x33 in order. DO holds 0x33 afterwards.
4. ADDR_W=4, CLEAR_ON_RESET=1: release RSTB -> BUSY=1 and READY=0 for 16 cycles. CS requests in that window are ignored. All 16 words then read 0, and a write attempted at cycle 5 is not stored.
5. Mid-clear reset: pulse RSTB=0 at clear cycle 7 -> clear restarts at address 0 and BUSY lasts 16 further cycles. CLR pulsed during the clear has no effect on its length.
6. OE=0 while a read of 0x2A5A5 completes -> VALID=1 and DO=0. Then raise OE -> DO=0x2A5A5 with no new VALID.
